tank_level_model: RTL and testbench
===================================

# tank_level_model

Sequential model of the irrigation reservoir that produces the tank level sensor lines `H`, `M` and `L`. The display and controller logic consume these lines. The block runs in the 50 MHz domain and takes a one-cycle-per-second enable. It drains the tank one level per `ASP_SECONDS` while sprinkling (`Bs`) and one level per `DRIP_SECONDS` while dripping (`Vs`). It refills on `fill`. It is used as the on-board stand-in for the physical float sensors and as the stimulus source for system benches.

## Interface
Parameters:
- `ASP_SECONDS`, 300: seconds per one-level drop while sprinkling (5 min); range 1..1023.
- `DRIP_SECONDS`, 600: seconds per one-level drop while dripping (10 min); range 1..1023.
- `FILL_SECONDS`, 60: seconds per one-level rise while filling; range 1..1023.
- `INIT_LEVEL`, 3: level loaded on reset; range 0..3.

Ports:
- `clock` in 1: 50 MHz system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sec_tick` in 1: one-cycle enable pulse, once per second, synchronous to `clock`.
- `Bs` in 1: sprinkler active.
- `Vs` in 1: drip active.
- `fill` in 1: refill pump active.
- `Error` in 1: fault; freezes the model.
- `H`, `M`, `L` out 1 each: level sensors, thermometer-coded, 1 = water at that height.
- `level` out 2: current level, 0 = empty, 3 = full.
- `empty` out 1: level == 0.
- `full` out 1: level == 3.
- `step` out 1: one-cycle pulse when `level` changes.

## Operation
- Mode is resolved each cycle by strict priority: `Error` → FAULT; `fill` → FILL; `Bs` → ASP; `Vs` → DRIP; none → IDLE. When `Bs` and `Vs` are both high, ASP wins.
- States are IDLE, ASP, DRIP, FILL and FAULT. The state register loads the resolved mode every cycle.
- The seconds counter is 10 bits, unsigned.
- Period by state: ASP uses `ASP_SECONDS`, DRIP uses `DRIP_SECONDS`, FILL uses `FILL_SECONDS`. IDLE and FAULT have no period.
- Mode change: if the resolved mode differs from the current state, the counter clears to 0 and the level does not change that cycle, even if `sec_tick` is high.
- Counting: in ASP, DRIP or FILL with `sec_tick` high and the mode unchanged:
  - if counter == period−1, the counter clears to 0, the level steps and `step` pulses;
  - otherwise the counter increments.
- Level step direction: ASP and DRIP decrement, FILL increments.
- Saturation:
  - ASP or DRIP at level 0: counter held at 0, no step, `empty` stays 1.
  - FILL at level 3: counter held at 0, no step, `full` stays 1.
- IDLE: counter holds its value; the level holds. The counter clears on the next mode change.
- FAULT: counter clears to 0; the level holds; `sec_tick` is ignored.
- Output decode from `level`: `H = (level==3)`, `M = (level>=2)`, `L = (level>=1)`. `empty` and `full` decode from `level`.
- Reset values:
  - state IDLE, counter 0, `level = INIT_LEVEL`, `step` 0;
  - `H`/`M`/`L`/`empty`/`full` decode from `INIT_LEVEL` (default: `H=M=L=1`, `full=1`, `empty=0`).

## Timing
- All outputs are registered or decoded from registers only; there is no combinational input-to-output path.
- Latency: with `sec_tick` high at edge N and counter == period−1, `level`, `H`/`M`/`L` and `step` change after edge N. `step` is high for exactly the one cycle following edge N.
- Drain time from level k to k−1 under a constant mode is exactly period `sec_tick` pulses, counted from the first tick after the mode became stable.
- The resolved mode is sampled at the same edge as `sec_tick`. A mode toggle on a tick cycle forfeits that tick.
- `reset` has priority over everything, including mid-count and mid-FAULT. The cycle after `reset` deasserts shows the reset values, and counting resumes from 0.
- `sec_tick` pulses longer than one cycle count once per cycle high. Upstream must guarantee single-cycle pulses.

## Test plan
- Reset with `INIT_LEVEL=3` → `H=M=L=1`, `level=3`, `full=1`, `empty=0`, `step=0`. Assert `reset` mid-drain at counter 3 → next cycle `level=3`, counter 0.
- `ASP_SECONDS=5`, `Bs=1`, `sec_tick` every 4th cycle:
  - 5 ticks → `level=2`, `H=0`, `M=L=1`, one `step` pulse;
  - 15 ticks total → `level=0`, `empty=1`;
  - 5 further ticks → no `step`.
- `DRIP_SECONDS=10`, `Bs=Vs=1` for 5 ticks, then `Bs=0` → counter clears on the switch; `level` drops only after 10 more ticks.
- From `level=0`, `FILL_SECONDS=3`, `fill=1` with `Bs=1` → FILL wins; `level` reaches 3 after 9 ticks; 3 more ticks give no further `step`.
- `Bs=1` at counter 4 of 5, then `Error=1` for 10 ticks → `level` frozen, no `step`. Then `Error=0` → 5 full ticks are needed before the decrement.
- `Bs=1`, counter 2, `Bs` dropped for 20 ticks (IDLE), then raised → mode change clears the counter; the decrement comes after 5 ticks, not 3.

Source files
------------

// File: rtl/tank_level_model_if.sv
// Signal bundle between the tank model and whatever drives its mode inputs.
// The model takes the slave side; a bench or controller takes the master side.
interface tank_level_model_if;
    logic       sec_tick;
    logic       Bs;
    logic       Vs;
    logic       fill;
    logic       Error;
    logic       H;
    logic       M;
    logic       L;
    logic [1:0] level;
    logic       empty;
    logic       full;
    logic       step;
    logic [2:0] dbg_state;

    modport master (
        output sec_tick, Bs, Vs, fill, Error,
        input  H, M, L, level, empty, full, step, dbg_state
    );

    modport slave (
        input  sec_tick, Bs, Vs, fill, Error,
        output H, M, L, level, empty, full, step, dbg_state
    );
endinterface

// File: rtl/tank_level_model.sv
// Reservoir level model: drains while sprinkling or dripping, refills on fill,
// and produces thermometer-coded float sensor lines from a 2-bit level.
module tank_level_model #(
    parameter int ASP_SECONDS  = 300,
    parameter int DRIP_SECONDS = 600,
    parameter int FILL_SECONDS = 60,
    parameter int INIT_LEVEL   = 3
) (
    input logic               clock,
    input logic               reset,
    tank_level_model_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ASP   = 3'd1,
        DRIP  = 3'd2,
        FILL  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [9:0] ASP_LAST  = 10'(ASP_SECONDS - 1);
    localparam logic [9:0] DRIP_LAST = 10'(DRIP_SECONDS - 1);
    localparam logic [9:0] FILL_LAST = 10'(FILL_SECONDS - 1);
    localparam logic [1:0] INIT_LVL  = 2'(INIT_LEVEL);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [1:0] level_q, level_d;
    logic       step_q, step_d;
    logic [9:0] last_sel;
    logic       saturated;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= INIT_LVL;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d   = IDLE;
        cnt_d     = cnt_q;
        level_d   = level_q;
        step_d    = 1'b0;
        last_sel  = ASP_LAST;
        saturated = 1'b0;

        if (bus.Error)     state_d = FAULT;
        else if (bus.fill) state_d = FILL;
        else if (bus.Bs)   state_d = ASP;
        else if (bus.Vs)   state_d = DRIP;

        case (state_q)
            DRIP:    last_sel = DRIP_LAST;
            FILL:    last_sel = FILL_LAST;
            default: last_sel = ASP_LAST;
        endcase
        saturated = (state_q == FILL) ? (level_q == 2'd3) : (level_q == 2'd0);

        // A mode change always restarts the period and forfeits any tick this cycle.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                FAULT: cnt_d = '0;
                ASP, DRIP, FILL: begin
                    if (saturated) begin
                        cnt_d = '0;
                    end else if (bus.sec_tick) begin
                        if (cnt_q == last_sel) begin
                            cnt_d   = '0;
                            step_d  = 1'b1;
                            level_d = (state_q == FILL) ? level_q + 2'd1 : level_q - 2'd1;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    assign bus.H         = (level_q == 2'd3);
    assign bus.M         = (level_q >= 2'd2);
    assign bus.L         = (level_q >= 2'd1);
    assign bus.level     = level_q;
    assign bus.empty     = (level_q == 2'd0);
    assign bus.full      = (level_q == 2'd3);
    assign bus.step      = step_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_tank_level_model.sv
// Bench for tank_level_model: directed scenarios plus random mode/tick traffic,
// every cycle compared against a behavioural reservoir model.
module tb_tank_level_model;
    localparam int ASP_P  = 5;
    localparam int DRIP_P = 10;
    localparam int FILL_P = 3;
    localparam int INIT_L = 3;

    logic clk;
    logic rst;
    tank_level_model_if bus ();

    tank_level_model #(
        .ASP_SECONDS (ASP_P),
        .DRIP_SECONDS(DRIP_P),
        .FILL_SECONDS(FILL_P),
        .INIT_LEVEL  (INIT_L)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks;
    int n_fail;
    int steps_seen;

    // Reference model: the active activity, how many ticks it has accumulated,
    // and the water level as an integer.
    string m_act;
    int    m_ticks;
    int    m_level;
    bit    m_step;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic string activity(input bit b, input bit v, input bit f, input bit e);
        if (e) return "fault";
        if (f) return "fill";
        if (b) return "sprinkle";
        if (v) return "drip";
        return "rest";
    endfunction

    task automatic model_edge(input bit b, input bit v, input bit f, input bit e, input bit t);
        string act;
        int period;
        int delta;
        act    = activity(b, v, f, e);
        m_step = 1'b0;
        if (rst) begin
            m_act = "rest"; m_ticks = 0; m_level = INIT_L;
            return;
        end
        if (act != m_act) begin
            m_act = act; m_ticks = 0;
            return;
        end
        if (act == "fault") begin
            m_ticks = 0;
            return;
        end
        if (act == "rest") return;
        period = (act == "sprinkle") ? ASP_P : (act == "drip") ? DRIP_P : FILL_P;
        delta  = (act == "fill") ? 1 : -1;
        if (m_level + delta < 0 || m_level + delta > 3) begin
            m_ticks = 0;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == period) begin
                m_ticks = 0;
                m_level += delta;
                m_step  = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("level", bus.level, m_level);
        check_eq("H", bus.H, (m_level == 3));
        check_eq("M", bus.M, (m_level >= 2));
        check_eq("L", bus.L, (m_level >= 1));
        check_eq("empty", bus.empty, (m_level == 0));
        check_eq("full", bus.full, (m_level == 3));
        check_eq("step", bus.step, m_step);
        if (bus.step === 1'b1) steps_seen++;
    endtask

    task automatic cycle(input bit b, input bit v, input bit f, input bit e, input bit t);
        bus.Bs = b; bus.Vs = v; bus.fill = f; bus.Error = e; bus.sec_tick = t;
        @(posedge clk);
        model_edge(b, v, f, e, t);
        #1;
        compare_all();
    endtask

    // One tick every fourth cycle, mode inputs held.
    task automatic run_ticks(input bit b, input bit v, input bit f, input bit e, input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 3; k++) cycle(b, v, f, e, 1'b0);
            cycle(b, v, f, e, 1'b1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; steps_seen = 0;
        m_act = "rest"; m_ticks = 0; m_level = INIT_L; m_step = 0;
        rst = 1'b1;
        bus.Bs = 0; bus.Vs = 0; bus.fill = 0; bus.Error = 0; bus.sec_tick = 0;
        #1;
        do_reset();
        check_eq("rst_level", bus.level, 3);
        check_eq("rst_hml", {bus.H, bus.M, bus.L}, 3'b111);
        check_eq("rst_full_empty", {bus.full, bus.empty}, 2'b10);
        check_eq("rst_step", bus.step, 0);

        // Sprinkle drain to empty, then saturation.
        steps_seen = 0;
        run_ticks(1, 0, 0, 0, 5);
        check_eq("asp_5_level", bus.level, 2);
        check_eq("asp_5_hml", {bus.H, bus.M, bus.L}, 3'b011);
        check_eq("asp_5_steps", steps_seen, 1);
        run_ticks(1, 0, 0, 0, 10);
        check_eq("asp_15_level", bus.level, 0);
        check_eq("asp_15_empty", bus.empty, 1);
        steps_seen = 0;
        run_ticks(1, 0, 0, 0, 5);
        check_eq("asp_sat_steps", steps_seen, 0);

        // Reset mid-drain restarts the count.
        do_reset();
        run_ticks(1, 0, 0, 0, 3);
        do_reset();
        check_eq("mid_rst_level", bus.level, 3);
        run_ticks(1, 0, 0, 0, 4);
        check_eq("mid_rst_4", bus.level, 3);
        run_ticks(1, 0, 0, 0, 1);
        check_eq("mid_rst_5", bus.level, 2);

        // Sprinkle+drip, then drip alone: count restarts at the switch.
        run_ticks(1, 1, 0, 0, 3);
        run_ticks(0, 1, 0, 0, 9);
        check_eq("drip_9", bus.level, 2);
        run_ticks(0, 1, 0, 0, 1);
        check_eq("drip_10", bus.level, 1);

        // Drain to empty, then fill beats sprinkle.
        run_ticks(1, 0, 0, 0, 6);
        check_eq("pre_fill_empty", bus.level, 0);
        run_ticks(1, 0, 1, 0, 9);
        check_eq("fill_9", bus.level, 3);
        steps_seen = 0;
        run_ticks(1, 0, 1, 0, 3);
        check_eq("fill_sat_steps", steps_seen, 0);

        // Fault freezes the level and discards partial progress.
        run_ticks(1, 0, 0, 0, 4);
        steps_seen = 0;
        run_ticks(1, 0, 0, 1, 10);
        check_eq("fault_level", bus.level, 3);
        check_eq("fault_steps", steps_seen, 0);
        run_ticks(1, 0, 0, 0, 4);
        check_eq("post_fault_4", bus.level, 3);
        run_ticks(1, 0, 0, 0, 1);
        check_eq("post_fault_5", bus.level, 2);

        // Idle keeps the level; resuming counts a full period.
        run_ticks(1, 0, 0, 0, 2);
        run_ticks(0, 0, 0, 0, 20);
        run_ticks(1, 0, 0, 0, 3);
        check_eq("idle_resume_3", bus.level, 2);
        run_ticks(1, 0, 0, 0, 2);
        check_eq("idle_resume_5", bus.level, 1);

        // Random traffic: modes held for random stretches, random ticks.
        for (int r = 0; r < 200; r++) begin
            bit b, v, f, e;
            int len;
            b = ($urandom_range(0, 1) == 1);
            v = ($urandom_range(0, 1) == 1);
            f = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 9) == 0);
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 49) == 0) do_reset();
            for (int k = 0; k < len; k++)
                cycle(b, v, f, e, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
